// File: rtl/pollard_sequencer.sv
// Pollard p-1 controller: iterates a <- a^j mod n for j = 2..B and tests gcd(a-1, n).
// It drives one shared modexp engine and one gcd engine through start/done handshakes.
module pollard_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BOUND_W = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   n,
  input  logic [BOUND_W-1:0] bound,
  output logic [WIDTH-1:0]   me_base,
  output logic [63:0]        me_exp,
  output logic [WIDTH-1:0]   me_mod,
  output logic               me_start,
  input  logic [WIDTH-1:0]   me_result,
  input  logic               me_done,
  output logic [WIDTH-1:0]   gcd_a,
  output logic [WIDTH-1:0]   gcd_b,
  output logic               gcd_start,
  input  logic [WIDTH-1:0]   gcd_result,
  input  logic               gcd_done,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               timeout_err,
  output logic [WIDTH-1:0]   factor,
  output logic [BOUND_W-1:0] iter
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StExpReq, StExpWait, StGcdReq, StGcdWait, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d, a_q, a_d, factor_q, factor_d;
  logic [BOUND_W-1:0] bound_q, bound_d, j_q, j_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic               found_q, found_d, terr_q, terr_d;
  logic               wd_expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      n_q      <= '0;
      a_q      <= WIDTH'(2);
      factor_q <= '0;
      bound_q  <= '0;
      j_q      <= BOUND_W'(2);
      wd_q     <= '0;
      found_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      factor_q <= factor_d;
      bound_q  <= bound_d;
      j_q      <= j_d;
      wd_q     <= wd_d;
      found_q  <= found_d;
      terr_q   <= terr_d;
    end
  end

  assign wd_expired = (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    factor_d = factor_q;
    bound_d  = bound_q;
    j_d      = j_q;
    found_d  = found_q;
    terr_d   = terr_q;
    // Watchdog only accumulates while parked in a wait state; any state change clears it.
    wd_d     = '0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StSetup;
          n_d      = n;
          bound_d  = bound;
          found_d  = 1'b0;
          terr_d   = 1'b0;
          factor_d = '0;
          a_d      = WIDTH'(2);
          j_d      = BOUND_W'(2);
        end
      end
      StSetup: begin
        if (n_q < WIDTH'(4)) begin
          state_d = StDone;
        end else if (!n_q[0]) begin
          state_d  = StDone;
          found_d  = 1'b1;
          factor_d = WIDTH'(2);
        end else if (bound_q < BOUND_W'(2)) begin
          state_d = StDone;
        end else begin
          state_d = StExpReq;
        end
      end
      StExpReq: state_d = StExpWait;
      StExpWait: begin
        if (me_done) begin
          a_d     = me_result;
          state_d = StGcdReq;
        end else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StGcdReq: state_d = StGcdWait;
      StGcdWait: begin
        if (gcd_done) begin
          if ((gcd_result > WIDTH'(1)) && (gcd_result < n_q)) begin
            found_d  = 1'b1;
            factor_d = gcd_result;
            state_d  = StDone;
          end else if ((gcd_result == WIDTH'(1)) && (j_q < bound_q)) begin
            j_d     = j_q + BOUND_W'(1);
            state_d = StExpReq;
          end else begin
            state_d = StDone;
          end
        end else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    me_base     = '0;
    me_exp      = '0;
    me_mod      = '0;
    me_start    = 1'b0;
    gcd_a       = '0;
    gcd_b       = '0;
    gcd_start   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    found       = found_q;
    timeout_err = terr_q;
    factor      = factor_q;
    iter        = (state_q == StIdle) ? '0 : j_q;
    case (state_q)
      StSetup: busy = 1'b1;
      StExpReq, StExpWait: begin
        busy     = 1'b1;
        me_base  = a_q;
        me_exp   = 64'(j_q);
        me_mod   = n_q;
        me_start = (state_q == StExpReq);
      end
      StGcdReq, StGcdWait: begin
        busy      = 1'b1;
        // a is reduced mod n, so a == 0 means a-1 wraps to n-1.
        gcd_a     = (a_q == '0) ? (n_q - WIDTH'(1)) : (a_q - WIDTH'(1));
        gcd_b     = n_q;
        gcd_start = (state_q == StGcdReq);
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

endmodule
